// File: rtl/sopu_kernel_pkg.sv
// Shared SoPU kernel-path definitions: streamer FSM states, default kernel size, weight width.
// Used by the kernel bank and the multiplier array as well as the streamer.
package sopu_kernel_pkg;

    localparam int unsigned KERNEL_SIZE_DEFAULT = 49;
    localparam int unsigned WEIGHT_WIDTH        = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } stream_state_t;

endpackage

// File: rtl/kernel_stream_fifo.sv
// Two-entry weight FIFO that absorbs memory returns while the kernel bank is paused.
// Clear is synchronous and active-high; pushing and popping in the same cycle is allowed.
module kernel_stream_fifo
    import sopu_kernel_pkg::*;
(
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WEIGHT_WIDTH-1:0] din,
    output logic [WEIGHT_WIDTH-1:0] dout,
    output logic [1:0]              count
);

    logic [WEIGHT_WIDTH-1:0] slots [2];
    logic                    wr_ptr;
    logic                    rd_ptr;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Storage needs no reset: the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            slots[wr_ptr] <= din;
        end
    end

    assign dout = slots[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (clear)
        !(push && !pop && count == 2'd2));

    a_no_underflow: assert property (@(posedge clk) disable iff (clear)
        !(pop && count == 2'd0));

endmodule

// File: rtl/kernel_streamer.sv
// Fetches one kernel of weights from synchronous memory and streams it to the kernel bank,
// one weight per cycle, with a pause input that stalls delivery without losing weights.
module kernel_streamer
    import sopu_kernel_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEFAULT,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    pause,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [WEIGHT_WIDTH-1:0] mem_rd_data,
    output logic [WEIGHT_WIDTH-1:0] new_kernel,
    output logic                    kernel_write_enable,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned    CW   = $clog2(KERNEL_SIZE + 1);
    localparam logic [CW-1:0]  LAST = CW'(KERNEL_SIZE);

    stream_state_t           state;
    stream_state_t           state_next;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [CW-1:0]           rd_cnt;
    logic [CW-1:0]           wr_cnt;
    logic                    in_flight;

    logic                    rd_issue;
    logic                    credit_ok;
    logic                    load;
    logic [WEIGHT_WIDTH-1:0] load_data;

    logic                    fifo_clear;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [WEIGHT_WIDTH-1:0] fifo_dout;
    logic [1:0]              fifo_count;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STREAM;
            STREAM:  if (wr_cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A read is only issued when its return is guaranteed a slot: the outstanding read
    // plus buffered weights never exceed the FIFO depth.
    always_comb begin
        credit_ok = (3'(in_flight) + 3'(fifo_count)) < 3'd2;
        rd_issue  = (state == STREAM) && (rd_cnt < LAST) && credit_ok;
        load      = (state == STREAM) && !pause && (in_flight || fifo_count != 2'd0);
        fifo_pop  = load && (fifo_count != 2'd0);
        fifo_push = in_flight && !(load && fifo_count == 2'd0);
        load_data = (fifo_count != 2'd0) ? fifo_dout : mem_rd_data;
        fifo_clear = rst || (state != IDLE && state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            base_q              <= '0;
            rd_cnt              <= '0;
            wr_cnt              <= '0;
            in_flight           <= 1'b0;
            new_kernel          <= '0;
            kernel_write_enable <= 1'b0;
        end else begin
            state               <= state_next;
            in_flight           <= rd_issue;
            kernel_write_enable <= load;
            if (state == IDLE && start) begin
                base_q <= base_addr;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_issue) begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
                if (load) begin
                    wr_cnt     <= wr_cnt + CW'(1);
                    new_kernel <= load_data;
                end
            end
        end
    end

    kernel_stream_fifo u_fifo (
        .clk   (clk),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_rd_data),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign mem_rd_en = rd_issue;
    assign mem_addr  = base_q + ADDR_WIDTH'(rd_cnt);
    assign busy      = (state == STREAM);
    assign done      = (state == DONE);

    a_read_count: assert property (@(posedge clk) disable iff (rst) rd_cnt <= LAST);

endmodule

// File: tb/tb_kernel_streamer.sv
// Self-checking bench for kernel_streamer: memory model plus a cycle-level reference of
// which cycles must carry a strobe and which weight it must carry.
module tb_kernel_streamer;

    localparam int K  = 49;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          pause;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic [7:0]    new_kernel;
    logic          kernel_write_enable;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    kernel_streamer #(.KERNEL_SIZE(K), .ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .base_addr           (base_addr),
        .pause               (pause),
        .mem_rd_en           (mem_rd_en),
        .mem_addr            (mem_addr),
        .mem_rd_data         (mem_rd_data),
        .new_kernel          (new_kernel),
        .kernel_write_enable (kernel_write_enable),
        .busy                (busy),
        .done                (done)
    );

    // Drive this cycle's inputs, then move to the next cycle's observation point.
    task automatic next_cycle(input logic s, input logic [AW-1:0] b, input logic p);
        start     = s;
        base_addr = b;
        pause     = p;
        @(negedge clk);
        cyc++;
    endtask

    task automatic fill_mem(input logic [AW-1:0] base, input bit rnd);
        for (int i = 0; i < K + 4; i++)
            mem[16'(base + i)] = rnd ? 8'($urandom) : 8'(i + 1);
    endtask

    // Runs one transfer from base and returns while observing the cycle that carries done.
    // Expected behaviour: strobe in cycle c iff c>=3, pause was low in c-1 and weights remain;
    // weights are memory[base+i] in order; done follows the last strobe by one cycle.
    task automatic run_stream(input logic [AW-1:0] base, input int pmode,
                              input int stray_cyc, input logic [AW-1:0] stray_base,
                              output int n_strobe, output int first_s, output int last_s,
                              output int first_rd, output int done_cyc);
        logic [7:0] expq[$];
        int         n_rd;
        logic       prev_p, p, s, exp_kwe, exp_done;
        bit         fin;
        for (int i = 0; i < K; i++) expq.push_back(mem[16'(base + i)]);
        n_strobe = 0; first_s = -1; last_s = -1; first_rd = -1; done_cyc = -1;
        n_rd = 0; prev_p = 1'b0; fin = 1'b0;
        cyc = 0;
        next_cycle(1'b1, base, 1'b0);
        while (!fin && cyc < 400) begin
            exp_kwe  = (cyc >= 3) && !prev_p && (n_strobe < K);
            exp_done = (n_strobe == K) && (last_s == cyc - 1);
            if (mem_rd_en === 1'b1) begin
                n_cmp++;
                if (mem_addr !== 16'(base + n_rd)) begin
                    n_fail++;
                    $display("FAIL rd_addr cyc=%0d got=%h want=%h", cyc, mem_addr, 16'(base + n_rd));
                end
                if (first_rd < 0) first_rd = cyc;
                n_rd++;
            end
            n_cmp++;
            if (kernel_write_enable !== exp_kwe) begin
                n_fail++;
                $display("FAIL strobe cyc=%0d got=%b want=%b", cyc, kernel_write_enable, exp_kwe);
            end
            if (kernel_write_enable === 1'b1) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_weight cyc=%0d got=%h want=none", cyc, new_kernel);
                end else begin
                    if (new_kernel !== expq[0]) begin
                        n_fail++;
                        $display("FAIL weight cyc=%0d got=%h want=%h", cyc, new_kernel, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                if (first_s < 0) first_s = cyc;
                last_s = cyc;
                n_strobe++;
            end
            n_cmp++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, exp_done);
            end
            n_cmp++;
            if (busy !== !exp_done) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, !exp_done);
            end
            if (exp_done || done === 1'b1) begin
                done_cyc = cyc;
                fin = 1'b1;
            end else begin
                case (pmode)
                    1:       p = (cyc >= 10 && cyc <= 14) || (cyc >= 20 && cyc <= 40 && cyc % 2 == 1);
                    2:       p = ($urandom_range(0, 2) == 0);
                    default: p = 1'b0;
                endcase
                s = (cyc == stray_cyc);
                prev_p = p;
                next_cycle(s, s ? stray_base : base, p);
            end
        end
        if (!fin) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout cyc=%0d got=no_done want=done", cyc);
        end
        n_cmp++;
        if (n_rd != K) begin
            n_fail++;
            $display("FAIL read_count got=%0d want=%0d", n_rd, K);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle(1'b0, 16'h0, 1'b0);
        next_cycle(1'b1, 16'h1234, 1'b1);
        n_cmp += 6;
        if (mem_rd_en !== 1'b0)           begin n_fail++; $display("FAIL rst_rd_en got=%b want=0", mem_rd_en); end
        if (mem_addr !== 16'h0)           begin n_fail++; $display("FAIL rst_addr got=%h want=0000", mem_addr); end
        if (new_kernel !== 8'h0)          begin n_fail++; $display("FAIL rst_kernel got=%h want=00", new_kernel); end
        if (kernel_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_kwe got=%b want=0", kernel_write_enable); end
        if (busy !== 1'b0)                begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (done !== 1'b0)                begin n_fail++; $display("FAIL rst_done got=%b want=0", done); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(1'b0, 16'h0, 1'b1);
            n_cmp++;
            if (busy !== 1'b0 || mem_rd_en !== 1'b0 || kernel_write_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_pause got=%b%b%b want=000", busy, mem_rd_en, kernel_write_enable);
            end
        end
    endtask

    task automatic test_nominal();
        int ns, fs, ls, fr, dc;
        fill_mem(16'd100, 1'b0);
        run_stream(16'd100, 0, -1, 16'h0, ns, fs, ls, fr, dc);
        n_cmp += 5;
        if (fr != 1)  begin n_fail++; $display("FAIL nom_first_read got=%0d want=1", fr); end
        if (fs != 3)  begin n_fail++; $display("FAIL nom_first_strobe got=%0d want=3", fs); end
        if (ls != 51) begin n_fail++; $display("FAIL nom_last_strobe got=%0d want=51", ls); end
        if (ns != K)  begin n_fail++; $display("FAIL nom_strobes got=%0d want=%0d", ns, K); end
        if (dc != 52) begin n_fail++; $display("FAIL nom_done_cycle got=%0d want=52", dc); end
        next_cycle(1'b0, 16'd100, 1'b1);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL nom_done_pulse got=%b%b want=00", done, busy);
        end
    endtask

    task automatic test_pause_pattern();
        int ns, fs, ls, fr, dc;
        fill_mem(16'd300, 1'b0);
        run_stream(16'd300, 1, -1, 16'h0, ns, fs, ls, fr, dc);
        n_cmp++;
        if (ns != K) begin n_fail++; $display("FAIL pause_strobes got=%0d want=%0d", ns, K); end
        next_cycle(1'b0, 16'd300, 1'b0);
    endtask

    task automatic test_addr_wrap();
        int ns, fs, ls, fr, dc;
        fill_mem(16'hFFF0, 1'b1);
        run_stream(16'hFFF0, 0, -1, 16'h0, ns, fs, ls, fr, dc);
        n_cmp += 2;
        if (ns != K)  begin n_fail++; $display("FAIL wrap_strobes got=%0d want=%0d", ns, K); end
        if (dc != 52) begin n_fail++; $display("FAIL wrap_done_cycle got=%0d want=52", dc); end
        next_cycle(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        int ns, fs, ls, fr, dc;
        fill_mem(16'd200, 1'b1);
        fill_mem(16'd500, 1'b1);
        run_stream(16'd200, 0, 20, 16'd500, ns, fs, ls, fr, dc);
        n_cmp++;
        if (ns != K) begin n_fail++; $display("FAIL busy_start_strobes got=%0d want=%0d", ns, K); end
        next_cycle(1'b1, 16'd700, 1'b0);  // start during DONE must be ignored
        n_cmp++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL start_in_done got=%b%b want=00", busy, mem_rd_en);
        end
        run_stream(16'd500, 0, -1, 16'h0, ns, fs, ls, fr, dc);
        n_cmp++;
        if (dc != 52) begin n_fail++; $display("FAIL restart_done_cycle got=%0d want=52", dc); end
        next_cycle(1'b0, 16'd500, 1'b0);
    endtask

    task automatic test_reset_mid();
        int ns, fs, ls, fr, dc;
        fill_mem(16'd800, 1'b1);
        cyc = 0;
        next_cycle(1'b1, 16'd800, 1'b0);
        while (cyc < 25) next_cycle(1'b0, 16'd800, 1'($urandom_range(0, 1)));
        rst = 1'b1;
        next_cycle(1'b0, 16'd800, 1'b0);
        rst = 1'b0;
        n_cmp++;
        if (mem_rd_en !== 1'b0 || mem_addr !== 16'h0 || new_kernel !== 8'h0 ||
            kernel_write_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%b %h %h %b %b %b want=0 0000 00 0 0 0",
                     mem_rd_en, mem_addr, new_kernel, kernel_write_enable, busy, done);
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle(1'b0, 16'd800, 1'b0);
            n_cmp++;
            if (kernel_write_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet cyc=%0d got=%b%b%b want=000", cyc, kernel_write_enable, done, busy);
            end
        end
        fill_mem(16'd900, 1'b1);
        run_stream(16'd900, 0, -1, 16'h0, ns, fs, ls, fr, dc);
        n_cmp++;
        if (ns != K) begin n_fail++; $display("FAIL midrst_restart got=%0d want=%0d", ns, K); end
        rst = 1'b1;  // reset coincides with the done pulse
        next_cycle(1'b0, 16'd900, 1'b0);
        rst = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || kernel_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL done_rst got=%b%b%b want=000", done, busy, kernel_write_enable);
        end
        next_cycle(1'b0, 16'd900, 1'b0);
    endtask

    task automatic test_random_pause();
        int ns, fs, ls, fr, dc;
        logic [AW-1:0] b;
        for (int r = 0; r < 4; r++) begin
            b = 16'($urandom);
            fill_mem(b, 1'b1);
            run_stream(b, 2, -1, 16'h0, ns, fs, ls, fr, dc);
            n_cmp++;
            if (ns != K) begin n_fail++; $display("FAIL rand_strobes run=%0d got=%0d want=%0d", r, ns, K); end
            next_cycle(1'b0, b, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; pause = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_pause_pattern();
        test_addr_wrap();
        test_start_while_busy();
        test_reset_mid();
        test_random_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kernel_streamer.md
# kernel_streamer

Fetches one kernel of `KERNEL_SIZE` 8-bit weights from a synchronous kernel memory and streams it to the kernel bank's write port as one weight per cycle. It drives `new_kernel` and `kernel_write_enable` in weight order 0..`KERNEL_SIZE`-1. It sits between the weight memory and the kernel bank in the SoPU, and is the writer side of the bank's serial load interface. A `pause` input throttles the stream without losing weights.

## Interface
- `KERNEL_SIZE`, 49: number of weights per kernel (≥2).
- `ADDR_WIDTH`, 16: kernel memory address width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one kernel transfer; sampled only in IDLE.
- `base_addr` in `ADDR_WIDTH`: address of weight 0; latched when `start` is accepted.
- `pause` in 1: consumer stall; while high, no new weight is presented.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out `ADDR_WIDTH`: read address, valid with `mem_rd_en`.
- `mem_rd_data` in 8: read data, valid exactly 1 cycle after `mem_rd_en`.
- `new_kernel` out 8: weight to the bank, qualified by `kernel_write_enable`.
- `kernel_write_enable` out 1: one-cycle write strobe per weight.
- `busy` out 1: high from the cycle after `start` is accepted through the last write strobe.
- `done` out 1: one-cycle pulse after the final weight is written.

## Operation
- FSM states:
  - IDLE: `start`=1 → STREAM, and latch `base_addr`; read counter and write counter both cleared.
  - STREAM: issue reads and emit weights. When the write counter reaches `KERNEL_SIZE`, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Read issue:
  - `mem_rd_en`=1 when in STREAM, reads issued < `KERNEL_SIZE`, and (in-flight reads + FIFO occupancy) < 2.
  - `mem_addr` = latched base + read index, modulo 2^`ADDR_WIDTH` (wraps silently).
- Return path: `mem_rd_data` is captured on the cycle after issue.
  - It bypasses into the output register if the FIFO is empty and `pause`=0.
  - Otherwise it is pushed into a 2-entry FIFO.
  - The credit rule guarantees the FIFO never overflows.
- Output register, evaluated each STREAM cycle:
  - `pause`=0 and (FIFO non-empty or bypass data present): load the oldest weight (FIFO first) and set `kernel_write_enable`=1 for the next cycle. Increment the write counter.
  - Otherwise: `kernel_write_enable`=0 next cycle and `new_kernel` holds its last value.
- Ordering is strictly ascending address. No weight is dropped or duplicated across any pause pattern.
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `new_kernel`=0, `kernel_write_enable`=0, `busy`=0, `done`=0. State=IDLE, counters=0, FIFO empty.
- Reset mid-transfer: returns to IDLE next cycle and discards in-flight data. No further write strobes are issued, and `done` is not pulsed.
- `pause` in IDLE or DONE has no effect.

## Timing
- Start sampled at cycle 0.
- Cycle 1: first `mem_rd_en` with `mem_addr`=base.
- Cycle 2: data returns.
- Cycle 3: first `kernel_write_enable`.
- With `pause` held low: strobes on cycles 3..`KERNEL_SIZE`+2 (3..51 for 49), contiguous. `done` is high on cycle `KERNEL_SIZE`+3 (52), and `busy` falls the same cycle.
- Pause latency: `pause` high in cycle t suppresses the strobe in cycle t+1. Deasserting it in cycle t allows a strobe in t+1 if data is buffered.
- Read issue resumes at the latest 1 cycle after FIFO space frees.
- Throughput is 1 weight/cycle in steady state; there are no bubbles when unpaused.
- Earliest next `start` accepted: the cycle after `done`.

## Structure
- Package `sopu_kernel_pkg`: FSM state enum (IDLE, STREAM, DONE), the default `KERNEL_SIZE` constant, and the weight width (8).
  - Shared with the kernel bank and the multiplier array.
- Sub-module `kernel_stream_fifo`: 2-entry, 8-bit synchronous FIFO with push/pop/count and synchronous active-high clear.
  - Cleared on `rst` and on entry to IDLE.
- Counter widths are `$clog2(KERNEL_SIZE+1)`.

## Test plan
- Nominal: memory[100+i]=i+1, `start` with `base_addr`=100, `pause`=0 → 49 contiguous strobes on cycles 3..51 with `new_kernel`=1..49 in order; `done` pulse on cycle 52; `busy` 1..51.
- Pause pattern: `pause` high for cycles 10–14 and on every odd cycle 20–40 → still exactly 49 strobes, values 1..49 in order. No strobe follows a cycle with `pause`=1. Neither the FIFO overflow assertion nor the read-count-≤49 assertion fires.
- Address wrap: `base_addr`=0xFFF0 → reads 0xFFF0..0xFFFF then 0x0000..0x0020. Data order is preserved.
- Start while busy: a second `start` with `base_addr`=500 at cycle 20 → ignored. The transfer completes from the original base. A `start` on the cycle after `done` begins a new transfer from 500.
- Reset mid-transfer: `rst` at cycle 25 → next cycle all outputs are at their reset values. No strobes or `done` follow, even though a read was in flight. A new `start` afterwards streams a full 49 weights.
- Reset during DONE: `rst` coinciding with `done` → IDLE, `done`=0 next cycle.
